// File: rtl/uart_loopback_fifo_if.sv
// Byte-stream bundle between the UART byte ports and the loopback FIFO engine.
// master = UART/top side driving RX bytes and TX status, slave = the engine.
interface uart_loopback_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
);
    logic [DATA_W-1:0]        rxData;
    logic                     rxDataValid;
    logic                     txBusy;
    logic [1:0]               mode;
    logic                     clear_ovf;
    logic [DATA_W-1:0]        txData;
    logic                     txDataValid;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     overflow;

    modport master (
        output rxData, rxDataValid, txBusy, mode, clear_ovf,
        input  txData, txDataValid, fifo_count, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  rxData, rxDataValid, txBusy, mode, clear_ovf,
        output txData, txDataValid, fifo_count, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/uart_loopback_fifo.sv
// Buffered UART byte loopback: RX bytes queue in a FIFO and are replayed to TX
// through a per-byte transform (pass, uppercase, hex dump, discard).
module uart_loopback_fifo #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HEX_SEP     = 1,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_loopback_fifo_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ToW  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] ModePass  = 2'b00;
    localparam logic [1:0] ModeUpper = 2'b01;
    localparam logic [1:0] ModeHex   = 2'b10;
    localparam logic [1:0] ModeDrop  = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitIdle} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                overflow_q;
    logic [DATA_W-1:0]   byte_q;
    logic [1:0]          mode_q;
    logic [1:0]          k_q;
    logic [ToW-1:0]      to_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                tx_valid_q;

    logic                full, empty, pop, push, drop;
    logic [1:0]          eff_mode;
    logic [1:0]          last_k;
    logic [7:0]          b8, c8;
    logic [DATA_W-1:0]   char_c;

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = (state_q == StIdle) && !empty && !bus.txBusy;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push  = bus.rxDataValid && (!full || pop);
    assign drop  = bus.rxDataValid && full && !pop;

    always_comb begin
        eff_mode = bus.mode;
        if (DATA_W != 8 && (bus.mode == ModeUpper || bus.mode == ModeHex)) begin
            eff_mode = ModePass;
        end
    end

    always_comb begin
        b8     = 8'(byte_q);
        c8     = b8;
        last_k = 2'd0;
        unique case (mode_q)
            ModeUpper: begin
                if (b8 >= 8'h61 && b8 <= 8'h7a) c8 = b8 - 8'h20;
            end
            ModeHex: begin
                last_k = (HEX_SEP != 0) ? 2'd2 : 2'd1;
                unique case (k_q)
                    2'd0:    c8 = hex_digit(b8[7:4]);
                    2'd1:    c8 = hex_digit(b8[3:0]);
                    default: c8 = 8'h20;
                endcase
            end
            default: c8 = b8;
        endcase
        char_c = (mode_q == ModePass) ? byte_q : DATA_W'(c8);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.rxData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // The strobe is registered out of StIssue, so it is visible while in StWaitAck.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_q     <= '0;
            mode_q     <= ModePass;
            k_q        <= '0;
            to_q       <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        byte_q <= mem_q[rd_ptr_q];
                        mode_q <= eff_mode;
                        k_q    <= '0;
                        if (eff_mode != ModeDrop) state_q <= StIssue;
                    end
                end
                StIssue: begin
                    tx_data_q  <= char_c;
                    tx_valid_q <= 1'b1;
                    to_q       <= '0;
                    state_q    <= StWaitAck;
                end
                StWaitAck: begin
                    // Timeout counts from the strobe cycle through the StWaitIdle check.
                    if (bus.txBusy || (int'(to_q) + 2 >= int'(ACK_TIMEOUT))) begin
                        state_q <= StWaitIdle;
                    end else begin
                        to_q <= to_q + ToW'(1);
                    end
                end
                StWaitIdle: begin
                    if (!bus.txBusy) begin
                        if (k_q != last_k) begin
                            k_q     <= k_q + 2'd1;
                            state_q <= StIssue;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.txData      = tx_data_q;
    assign bus.txDataValid = tx_valid_q;
    assign bus.fifo_count  = count_q;
    assign bus.fifo_full   = full;
    assign bus.fifo_empty  = empty;
    assign bus.overflow    = overflow_q;
endmodule
